// File: rtl/lane_queue_tracker.sv
// lane_queue_tracker: per-lane car queue counters with green-timed departures,
// busiest-lane indication and an emergency request latch feeding Breadboard.
module lane_queue_tracker #(
    parameter int DEPART_PERIOD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  carArrive,
    input  logic [7:0]  greenIn,
    input  logic        emgReq,
    input  logic [7:0]  emgReqLane,
    input  logic        emgClear,
    output logic [63:0] lanes,
    output logic        emgSignal,
    output logic [7:0]  emgLane,
    output logic [7:0]  busiestLane,
    output logic [7:0]  satFlag
);
    localparam int TW = DEPART_PERIOD > 2 ? $clog2(DEPART_PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(DEPART_PERIOD - 1);

    typedef enum logic {IDLE, ACTIVE} emg_state_t;

    logic [7:0][7:0]    r_cnt, w_cnt_nxt;
    logic [7:0][TW-1:0] r_tmr, w_tmr_nxt;
    logic [7:0]         r_sat, w_sat_nxt;
    logic [7:0]         r_busy, w_busy, w_best;
    logic [7:0]         w_serve, w_dep, w_lost;
    logic               r_emg_sig, w_req_ok;
    logic [7:0]         r_emg_lane;
    emg_state_t         r_state;

    // Arrival and departure together cancel; an arrival is lost only when it would overflow.
    always_comb begin
        w_serve   = '0;
        w_dep     = '0;
        w_lost    = '0;
        w_cnt_nxt = r_cnt;
        w_tmr_nxt = r_tmr;
        w_sat_nxt = r_sat;
        for (int k = 0; k < 8; k++) begin
            w_serve[k]   = greenIn[k] && r_cnt[k] != 8'd0;
            w_dep[k]     = w_serve[k] && r_tmr[k] == LAST;
            w_lost[k]    = carArrive[k] && !w_dep[k] && r_cnt[k] == 8'hFF;
            w_cnt_nxt[k] = (carArrive[k] == w_dep[k] || w_lost[k]) ? r_cnt[k] :
                           carArrive[k] ? r_cnt[k] + 8'd1 : r_cnt[k] - 8'd1;
            w_tmr_nxt[k] = (!w_serve[k] || w_dep[k]) ? '0 : r_tmr[k] + TW'(1);
            w_sat_nxt[k] = r_sat[k] | w_lost[k];
        end
    end

    // Ascending scan with >= lets the highest index win ties.
    always_comb begin
        w_best = '0;
        w_busy = '0;
        for (int k = 0; k < 8; k++) begin
            if (r_cnt[k] != 8'd0 && r_cnt[k] >= w_best) begin
                w_best = r_cnt[k];
                w_busy = 8'd1 << k;
            end
        end
    end

    assign w_req_ok = emgReq && emgReqLane != 8'd0 && (emgReqLane & (emgReqLane - 8'd1)) == 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tmr  <= '0;
            r_sat  <= '0;
            r_busy <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tmr  <= w_tmr_nxt;
            r_sat  <= w_sat_nxt;
            r_busy <= w_busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_emg_sig  <= 1'b0;
            r_emg_lane <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_req_ok) begin
                    r_state    <= ACTIVE;
                    r_emg_sig  <= 1'b1;
                    r_emg_lane <= emgReqLane;
                end
                ACTIVE: if (emgClear) begin
                    r_state    <= IDLE;
                    r_emg_sig  <= 1'b0;
                    r_emg_lane <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lanes       = r_cnt;
    assign busiestLane = r_busy;
    assign satFlag     = r_sat;
    assign emgSignal   = r_emg_sig;
    assign emgLane     = r_emg_lane;
endmodule

// File: tb/tb_lane_queue_tracker.sv
// tb_lane_queue_tracker: directed sequences, an emergency vector table and
// randomized traffic checked against a queue-level reference model.
module tb_lane_queue_tracker;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  car = '0, green = '0, req_lane = '0;
    logic        req = 1'b0, clr = 1'b0;
    logic [63:0] lanes;
    logic        emg_sig;
    logic [7:0]  emg_lane, busy, sat;

    lane_queue_tracker #(.DEPART_PERIOD(DP)) dut (
        .clk(clk), .rst(rst), .carArrive(car), .greenIn(green),
        .emgReq(req), .emgReqLane(req_lane), .emgClear(clr),
        .lanes(lanes), .emgSignal(emg_sig), .emgLane(emg_lane),
        .busiestLane(busy), .satFlag(sat)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int m_cnt[8], m_run[8];
    logic [7:0] m_sat, m_busy, m_elane;
    logic       m_eact;

    typedef struct {
        logic       rq;
        logic [7:0] ln;
        logic       cl;
        logic       exp_sig;
        logic [7:0] exp_ln;
    } emg_vec_t;
    emg_vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] argmax();
        int best = 0;
        logic [7:0] r = '0;
        for (int k = 7; k >= 0; k--)
            if (m_cnt[k] > best) begin
                best = m_cnt[k];
                r = 8'd1 << k;
            end
        return r;
    endfunction

    function automatic logic [63:0] exp_lanes();
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(m_cnt[k]);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_cnt[k] = 0;
            m_run[k] = 0;
        end
        m_sat = '0; m_busy = '0; m_elane = '0; m_eact = 1'b0;
    endtask

    // A car leaves after DP consecutive served cycles; unserved time is forfeited.
    task automatic model_edge();
        logic [7:0] nb = argmax();
        for (int k = 0; k < 8; k++) begin
            bit served = green[k] && m_cnt[k] > 0;
            bit leave  = served && (m_run[k] + 1 == DP);
            if (car[k] && !leave) begin
                if (m_cnt[k] == 255) m_sat[k] = 1'b1;
                else m_cnt[k]++;
            end else if (leave && !car[k]) m_cnt[k]--;
            m_run[k] = (served && !leave) ? m_run[k] + 1 : 0;
        end
        if (!m_eact) begin
            if (req && $countones(req_lane) == 1) begin
                m_eact = 1'b1;
                m_elane = req_lane;
            end
        end else if (clr) begin
            m_eact = 1'b0;
            m_elane = '0;
        end
        m_busy = nb;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".lanes"}, lanes, exp_lanes());
        chk({tag, ".busiest"}, 64'(busy), 64'(m_busy));
        chk({tag, ".sat"}, 64'(sat), 64'(m_sat));
        chk({tag, ".emgSignal"}, 64'(emg_sig), 64'(m_eact));
        chk({tag, ".emgLane"}, 64'(emg_lane), 64'(m_elane));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        car = '0; green = '0; req = 1'b0; clr = 1'b0; req_lane = '0;
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #7;
        check_all("reset");
        rst = 1'b0;

        car = 8'h08;
        tick();
        chk("arr_latency", 64'(lanes[31:24]), 64'd1);
        chk("busy_latency", 64'(busy), 64'd0);
        tick(); tick();
        car = '0;
        chk("s1_three", 64'(lanes[31:24]), 64'd3);
        tick();
        chk("busy_s1", 64'(busy), 64'h08);
        check_all("arrival");

        car = 8'h80;
        repeat (255) tick();
        chk("n1_255", 64'(lanes[63:56]), 64'd255);
        chk("sat_clear", 64'(sat), 64'd0);
        tick();
        car = '0;
        chk("n1_hold", 64'(lanes[63:56]), 64'd255);
        chk("sat_n1", 64'(sat[7]), 64'd1);
        tick();
        check_all("saturation");
        do_reset();
        chk("rst_lanes", lanes, 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);

        car = 8'h80;
        repeat (5) tick();
        car = '0;
        green = 8'h80;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 4) chk("dep_first", 64'(lanes[63:56]), 64'd4);
            if (e == 8) chk("dep_second", 64'(lanes[63:56]), 64'd3);
            check_all("depart");
        end
        green = '0;
        tick();
        green = 8'h80;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 3) chk("dep_no_carry", 64'(lanes[63:56]), 64'd3);
            if (e == 4) chk("dep_reraise", 64'(lanes[63:56]), 64'd2);
            check_all("reraise");
        end
        do_reset();

        car = 8'h40;
        tick(); tick();
        car = '0;
        green = 8'h40;
        repeat (3) tick();
        car = 8'h40;
        tick();
        car = '0;
        chk("simul_n2", 64'(lanes[55:48]), 64'd2);
        tick();
        check_all("simul");
        do_reset();

        car = 8'h30;
        repeat (7) tick();
        car = '0;
        tick();
        chk("tie_e1", 64'(lanes[47:40]), 64'd7);
        chk("tie_busy", 64'(busy), 64'h20);
        do_reset();

        tbl[0] = '{1'b1, 8'h08, 1'b0, 1'b1, 8'h08};
        tbl[1] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h08};
        tbl[2] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 8'h18, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h04};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        for (int i = 0; i < 9; i++) begin
            req = tbl[i].rq; req_lane = tbl[i].ln; clr = tbl[i].cl;
            tick();
            chk($sformatf("emg%0d.sig", i), 64'(emg_sig), 64'(tbl[i].exp_sig));
            chk($sformatf("emg%0d.lane", i), 64'(emg_lane), 64'(tbl[i].exp_ln));
            check_all("emg_tbl");
        end
        req = 1'b0; clr = 1'b0; req_lane = '0;

        for (int c = 0; c < 3000; c++) begin
            car = 8'($urandom & $urandom);
            if ($urandom_range(7) == 0) green = 8'($urandom);
            req = $urandom_range(15) == 0;
            req_lane = $urandom_range(1) ? 8'd1 << $urandom_range(7) : 8'($urandom);
            clr = $urandom_range(15) == 0;
            tick();
            check_all("rand");
            if (c % 700 == 699) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lane_queue_tracker.md
# lane_queue_tracker

Upstream feeder for the traffic-light `Breadboard`. It keeps a per-lane car-queue count from arrival pulses and from departures timed by the current green lights, and drives the 64-bit `lanes` bus that `Breadboard` consumes. It also latches emergency requests into the `emgSignal`/`emgLane` pair. It replaces the hand-driven lane registers used in simulation with a closed loop: lights out of `Breadboard` feed `greenIn` here, and counts here feed `Breadboard`.

## Interface
Parameters:
- `DEPART_PERIOD`, default 4: cycles of continuous green per departing car; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `carArrive`, in, 8: one-cycle pulse per arriving car. Bit order: bit7=n1, bit6=n2, bit5=e1, bit4=e2, bit3=s1, bit2=s2, bit1=w1, bit0=w2.
- `greenIn`, in, 8: per-lane green indication, 1 = green; same bit order.
- `emgReq`, in, 1: emergency request pulse.
- `emgReqLane`, in, 8: one-hot lane of the request, sampled with `emgReq`.
- `emgClear`, in, 1: emergency has passed.
- `lanes`, out, 64: `{n1,n2,e1,e2,s1,s2,w1,w2}`, 8 bits each, n1 at [63:56].
- `emgSignal`, out, 1: emergency active.
- `emgLane`, out, 8: one-hot lane of the active emergency; 0 when inactive.
- `busiestLane`, out, 8: one-hot lane with the largest count; 0 if all counts are 0.
- `satFlag`, out, 8: sticky per lane; set when an arrival is lost at count 255.

## Operation
- **Counters.** Eight 8-bit queue counters, each with a departure timer of width ceil(log2(DEPART_PERIOD)), minimum 1 bit.
- **Arrival.**
  - `carArrive[i]` increments count i.
  - At count 255 the arrival is dropped and `satFlag[i]` is set.
- **Departure timer.**
  - Runs only while `greenIn[i]`=1 and count i > 0.
  - When the timer equals DEPART_PERIOD-1, the next edge fires a departure: count i decrements and the timer returns to 0. Otherwise the timer increments.
  - The timer clears to 0 whenever `greenIn[i]`=0 or count i = 0. Partial green time does not carry over.
- **Arrival and departure in the same cycle:** count unchanged. The timer still wraps to 0.
- **Departure at count 0:** cannot occur, because the timer is held at 0.
- **busiestLane.**
  - Registered; computed from the counter values in the current cycle.
  - On a tie, the highest bit index wins (n1 over n2 over … w2).
- **Emergency latch.** States IDLE and ACTIVE.
  - IDLE → ACTIVE when `emgReq`=1 and `emgReqLane` is exactly one-hot. On entry, `emgLane` takes `emgReqLane` and `emgSignal`=1.
  - A request with zero or multiple bits set is ignored.
  - In ACTIVE, further `emgReq` is ignored; the first lane is held.
  - ACTIVE → IDLE on `emgClear`. On exit, `emgSignal`=0 and `emgLane`=0.
  - `emgClear` in IDLE is a no-op.
  - `emgReq` and `emgClear` in the same cycle: in IDLE the request is accepted; in ACTIVE the clear wins and the request is dropped, not queued.
- **satFlag** clears only on `rst`.

## Timing
- **Reset values:** `lanes`=0, all timers 0, `satFlag`=0, `busiestLane`=0, `emgSignal`=0, `emgLane`=0, state IDLE.
- **Reset mid-operation:** all of the above values apply immediately and asynchronously. Inputs present at the first edge after `rst` falls are processed normally.
- **Arrival latency:** a pulse sampled at edge k appears on `lanes` after edge k.
- **busiestLane latency:** reflects counts one edge after they appear on `lanes`, i.e. 2 edges after the arrival.
- **Departure timing:** with green asserted before edge 1 and held, the first departure is visible after edge DEPART_PERIOD, then every DEPART_PERIOD edges.
- **Emergency latency:** `emgSignal`/`emgLane` update after the edge that samples `emgReq`/`emgClear`; 1 cycle.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Reset:** assert `rst` mid-clock with non-zero counts → all outputs 0 immediately, before the next edge.
- **Arrival/saturation:** 3 pulses on bit3 (s1), green off → `lanes`[31:24]=3, `busiestLane`=8'b00001000 one edge later. Then 255 pulses on bit7 (n1) → n1=255. A 256th pulse → n1 stays 255, `satFlag`[7]=1.
- **Departure:** n1=5, DEPART_PERIOD=4, `greenIn`[7] held 10 edges → n1=4 after edge 4, n1=3 after edge 8. Drop green at edge 10, re-raise → next departure 4 edges after the re-raise.
- **Simultaneous:** n2=2, green, and an arrival on the same edge as a scheduled departure → n2 stays 2.
- **Emergency:**
  - `emgReq` with `emgReqLane`=8'b00001000 → `emgSignal`=1, `emgLane`=8'b00001000.
  - A second request on 8'b10000000 → ignored.
  - `emgReq`+`emgClear` together in ACTIVE → IDLE, outputs 0.
  - A request with 8'b00011000 in IDLE → ignored.
- **Tie:** e1=e2=7, all other lanes 0 → `busiestLane`=8'b00100000.
